frame_capture_sequencer: RTL and testbench
==========================================

Name: frame_capture_sequencer

Overview:
- Parametrised successor to the single-shot camera capture controller. Runs entirely in the pixel clock domain. Callers synchronise cap_req and abort beforehand.
- Supports three modes: single frame, N-frame burst and continuous capture. Optional frame decimation skips K frames between captured frames.
- Checks each captured frame for line-count integrity.
- Drives the write-enable gate of the frame buffer writer and reports progress to the top-level control FSM.

Parameters:
- VSYNC_ACTIVE_HIGH, 1: vsync polarity. The frame boundary is the active-to-inactive edge of vsync.
- CNT_W, 8: width of burst_len and frames_captured.
- SKIP_W, 4: width of the skip field.
- LINE_W, 10: width of the line counter.
- EXP_LINES, 240: expected href-high lines per frame, used for the integrity check.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- cap_req  in  1  start request, single-cycle pulse, already synchronised
- abort  in  1  stop request, single-cycle pulse, already synchronised
- mode  in  2  0 = single, 1 = burst, 2 = continuous, 3 = reserved (treated as single)
- burst_len  in  CNT_W  frames per burst; 0 is treated as 1
- skip  in  SKIP_W  frames skipped between captured frames
- vsync  in  1  camera vsync
- href  in  1  camera href
- capture_enable  out  1  high while the current frame is being stored
- frame_start  out  1  one-cycle pulse when a captured frame begins
- frame_done  out  1  one-cycle pulse when a captured frame ends normally
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when the line count is not EXP_LINES
- busy  out  1  high in any state other than IDLE
- frames_captured  out  CNT_W  completed frames since the last accepted cap_req; saturates at all-ones

Behaviour:
- Reset:
  - All outputs are 0; the state is IDLE.
  - vsync_prev is reset to the active level, so a boundary can be detected immediately after reset.
  - Asserting reset mid-operation clears everything asynchronously; no frame_done is produced.
- Boundary detect:
  - vsync_prev is registered.
  - boundary = (vsync_prev == active) && (vsync == inactive), evaluated combinationally.
  - The state reacts on the same clock edge, so capture_enable rises one cycle after the first inactive vsync sample.
- Line counting:
  - Counts href rising edges while in CAPTURE, using a registered href_prev.
  - Cleared on every frame_start and saturates at 2^LINE_W-1.
- Config latching: mode, burst_len and skip are latched when cap_req is accepted. Later changes to these inputs have no effect until the next accepted request.
- IDLE:
  - cap_req moves to ARM and clears frames_captured.
  - abort has no effect.
- ARM:
  - On boundary: go to CAPTURE, set capture_enable = 1, pulse frame_start, clear the line counter.
- CAPTURE, on boundary:
  - Increment frames_captured, pulse frame_done, and pulse frame_err if line_cnt != EXP_LINES.
  - Then go to the next state as follows:
    - single mode, or burst with frames_captured+1 == burst_len: go to IDLE and clear capture_enable.
    - otherwise, skip == 0: stay in CAPTURE, keep capture_enable high, pulse frame_start in the same cycle as frame_done, clear the line counter.
    - otherwise, skip > 0: go to SKIP, clear capture_enable, load skip_cnt = skip.
- SKIP:
  - Each boundary decrements skip_cnt.
  - A boundary that arrives with skip_cnt == 1 enters CAPTURE with frame_start.
- Continuous mode never completes on its own; it ends only on abort.
- abort in ARM, CAPTURE or SKIP:
  - Go to IDLE on the next edge and clear capture_enable.
  - Suppress frame_done and frame_err, even if a boundary occurs in the same cycle (abort has priority).
  - frames_captured holds its value.
- cap_req while busy is ignored. cap_req coincident with abort in IDLE is accepted (abort is a no-op in IDLE).
- href activity outside CAPTURE is ignored.

Decomposition:
- Shared package cam_pkg:
  - capture_mode_e: MODE_SINGLE, MODE_BURST, MODE_CONT.
  - cap_state_e: IDLE, ARM, CAPTURE, SKIP.
- One natural sub-module, edge_detect: registered rise/fall detection with a parametrised reset level. It is instantiated for vsync and for href.

Test Plan:
1. Single mode, 3 frames of 240 lines, cap_req mid-frame 1: capture_enable is high during frame 2 only; one frame_start and one frame_done; frame_err = 0; frames_captured = 1; busy drops after the frame_done cycle.
2. Burst, burst_len = 3, skip = 0, 240-line frames: capture_enable stays high across 3 consecutive frames; frame_start coincides with frame_done at the internal boundaries; frames_captured = 3; then IDLE.
3. Burst, burst_len = 2, skip = 2: captures frames 1 and 4 relative to arm; capture_enable is low for frames 2 and 3; frames_captured = 2.
4. Continuous, skip = 0; abort in the 5th frame on the same cycle as a boundary: no frame_done on that cycle; capture_enable is 0 on the next cycle; frames_captured = 4.
5. Single mode with a 239-line frame: frame_done and frame_err pulse together. Then a cap_req while busy: ignored, with frames_captured unchanged.
6. Asynchronous reset asserted mid-CAPTURE between clock edges: all outputs are 0 immediately. After reset, a falling vsync with no cap_req leaves capture_enable at 0.

Source files
------------

// File: rtl/frame_capture_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// cam_pkg : shared types for the frame capture sequencer
// Rev 1.0
// ============================================================================
package cam_pkg;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'd0,
      MODE_BURST  = 2'd1,
      MODE_CONT   = 2'd2
   } capture_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      SKIP    = 2'd3
   } cap_state_e;

   // The reserved encoding behaves as single-frame capture.
   function automatic capture_mode_e decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_SINGLE : capture_mode_e'(m);
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_capture_sequencer_if.sv
`default_nettype none
// ============================================================================
// frame_capture_sequencer_if : request, camera timing and status signals
// Rev 1.0
// ============================================================================
interface frame_capture_sequencer_if #(
   parameter int CNT_W  = 8,
   parameter int SKIP_W = 4
);
   logic              cap_req;
   logic              abort;
   logic [1:0]        mode;
   logic [CNT_W-1:0]  burst_len;
   logic [SKIP_W-1:0] skip;
   logic              vsync;
   logic              href;
   logic              capture_enable;
   logic              frame_start;
   logic              frame_done;
   logic              frame_err;
   logic              busy;
   logic [CNT_W-1:0]  frames_captured;

   modport master (
      output cap_req, abort, mode, burst_len, skip, vsync, href,
      input  capture_enable, frame_start, frame_done, frame_err, busy, frames_captured
   );

   modport slave (
      input  cap_req, abort, mode, burst_len, skip, vsync, href,
      output capture_enable, frame_start, frame_done, frame_err, busy, frames_captured
   );
endinterface
`default_nettype wire

// File: rtl/frame_capture_sequencer_edge_detect.sv
`default_nettype none
// ============================================================================
// edge_detect : registered single-edge detector with selectable reset level
// Rev 1.0
// ============================================================================
module edge_detect #(
   parameter logic RESET_LEVEL = 1'b0,
   parameter logic DETECT_FALL = 1'b0
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  i_d,
   output logic o_edge
);
   logic r_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= RESET_LEVEL;
      else       r_prev <= i_d;
   end

   assign o_edge = DETECT_FALL ? (r_prev & ~i_d) : (~r_prev & i_d);
endmodule
`default_nettype wire

// File: rtl/frame_capture_sequencer.sv
`default_nettype none
// ============================================================================
// frame_capture_sequencer : single / burst / continuous frame capture gating
// Rev 1.0
// ============================================================================
module frame_capture_sequencer
   import cam_pkg::*;
#(
   parameter logic VSYNC_ACTIVE_HIGH = 1'b1,
   parameter int   CNT_W             = 8,
   parameter int   SKIP_W            = 4,
   parameter int   LINE_W            = 10,
   parameter int   EXP_LINES         = 240
) (
   input  wire                       clk,
   input  wire                       reset,
   frame_capture_sequencer_if.slave  bus
);
   localparam logic [LINE_W-1:0] c_line_max  = '1;
   localparam logic [LINE_W-1:0] c_exp_lines = LINE_W'(EXP_LINES);
   localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

   cap_state_e        r_state;
   cap_state_e        w_next_state;
   capture_mode_e     r_mode;
   logic [CNT_W-1:0]  r_burst_len;
   logic [CNT_W-1:0]  r_frames;
   logic [SKIP_W-1:0] r_skip;
   logic [SKIP_W-1:0] r_skip_cnt;
   logic [LINE_W-1:0] r_line_cnt;
   logic              w_boundary;
   logic              w_href_rise;
   logic              w_last_frame;
   logic              w_capture_enable;
   logic              w_frame_start;
   logic              w_frame_done;
   logic              w_frame_err;
   logic              w_busy;

   // Frame boundary is the active-to-inactive vsync transition.
   edge_detect #(.RESET_LEVEL(VSYNC_ACTIVE_HIGH), .DETECT_FALL(VSYNC_ACTIVE_HIGH)) u_vsync_edge (
      .clk    (clk),
      .reset  (reset),
      .i_d    (bus.vsync),
      .o_edge (w_boundary)
   );

   edge_detect #(.RESET_LEVEL(1'b0), .DETECT_FALL(1'b0)) u_href_edge (
      .clk    (clk),
      .reset  (reset),
      .i_d    (bus.href),
      .o_edge (w_href_rise)
   );

   assign w_last_frame = (r_mode == MODE_SINGLE) ||
                         ((r_mode == MODE_BURST) &&
                          (({1'b0, r_frames} + (CNT_W+1)'(1)) == {1'b0, r_burst_len}));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.cap_req) w_next_state = ARM;
         ARM: begin
            if (bus.abort)       w_next_state = IDLE;
            else if (w_boundary) w_next_state = CAPTURE;
         end
         CAPTURE: begin
            if (bus.abort)             w_next_state = IDLE;
            else if (w_boundary) begin
               if (w_last_frame)       w_next_state = IDLE;
               else if (r_skip == '0)  w_next_state = CAPTURE;
               else                    w_next_state = SKIP;
            end
         end
         SKIP: begin
            if (bus.abort) w_next_state = IDLE;
            else if (w_boundary && (r_skip_cnt == SKIP_W'(1))) w_next_state = CAPTURE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Abort outranks a coincident boundary, so it masks every pulse.
   always_comb begin
      w_capture_enable = (r_state == CAPTURE);
      w_busy           = (r_state != IDLE);
      w_frame_start    = 1'b0;
      w_frame_done     = 1'b0;
      if (w_boundary && !bus.abort) begin
         case (r_state)
            ARM:     w_frame_start = 1'b1;
            CAPTURE: begin
               w_frame_done  = 1'b1;
               w_frame_start = !w_last_frame && (r_skip == '0);
            end
            SKIP:    w_frame_start = (r_skip_cnt == SKIP_W'(1));
            default: w_frame_start = 1'b0;
         endcase
      end
      w_frame_err = w_frame_done && (r_line_cnt != c_exp_lines);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode      <= MODE_SINGLE;
         r_burst_len <= '0;
         r_skip      <= '0;
         r_skip_cnt  <= '0;
         r_frames    <= '0;
         r_line_cnt  <= '0;
      end else begin
         if ((r_state == IDLE) && bus.cap_req) begin
            r_mode      <= decode_mode(bus.mode);
            r_burst_len <= (bus.burst_len == '0) ? CNT_W'(1) : bus.burst_len;
            r_skip      <= bus.skip;
            r_frames    <= '0;
         end else if (w_frame_done && (r_frames != c_cnt_max)) begin
            r_frames <= r_frames + CNT_W'(1);
         end

         if (w_frame_start)
            r_line_cnt <= '0;
         else if ((r_state == CAPTURE) && w_href_rise && (r_line_cnt != c_line_max))
            r_line_cnt <= r_line_cnt + LINE_W'(1);

         if ((r_state == CAPTURE) && (w_next_state == SKIP))
            r_skip_cnt <= r_skip;
         else if ((r_state == SKIP) && w_boundary)
            r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
      end
   end

   assign bus.capture_enable  = w_capture_enable;
   assign bus.frame_start     = w_frame_start;
   assign bus.frame_done      = w_frame_done;
   assign bus.frame_err       = w_frame_err;
   assign bus.busy            = w_busy;
   assign bus.frames_captured = r_frames;
endmodule
`default_nettype wire

// File: tb/tb_frame_capture_sequencer.sv
`default_nettype none
// ============================================================================
// tb_frame_capture_sequencer : frame-level model checks of capture sequencing
// Rev 1.0
// ============================================================================
module tb_frame_capture_sequencer;
   logic clk = 1'b0;
   logic reset;

   frame_capture_sequencer_if #(.CNT_W(8), .SKIP_W(4)) bus ();

   frame_capture_sequencer #(
      .VSYNC_ACTIVE_HIGH (1'b1),
      .CNT_W             (8),
      .SKIP_W            (4),
      .LINE_W            (10),
      .EXP_LINES         (240)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_start = 0, n_done = 0, n_err = 0;
   int d_start, d_done, d_err;
   int fno = 0;
   int cfg_mode, cfg_len, cfg_skip;
   logic f_start, f_done, f_err, f_en_next, f_en_late, f_busy_late;
   logic [7:0] f_frames_late;

   // Frame-level model: a session captures every (skip+1)-th frame after arming.
   bit m_active = 0;
   bit m_cur_cap = 0;
   int m_pos = 0, m_mode = 0, m_len = 1, m_skip = 0, m_frames = 0, m_cur_lines = 0;

   always @(negedge clk) begin
      if (bus.frame_start === 1'b1) n_start++;
      if (bus.frame_done  === 1'b1) n_done++;
      if (bus.frame_err   === 1'b1) n_err++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_abort();
      m_active  = 0;
      m_cur_cap = 0;
   endtask

   task automatic model_req();
      if (!m_active) begin
         m_active = 1;
         m_pos    = 0;
         m_frames = 0;
         m_mode   = (cfg_mode == 3) ? 0 : cfg_mode;
         m_len    = (cfg_len == 0) ? 1 : cfg_len;
         m_skip   = cfg_skip;
      end
   endtask

   task automatic model_boundary(input int lines, output bit es, output bit ed, output bit ee);
      ed = m_active && m_cur_cap;
      ee = ed && (m_cur_lines != 240);
      if (ed) begin
         if (m_frames < 255) m_frames++;
         if (m_mode == 0 || (m_mode == 1 && m_frames >= m_len)) m_active = 0;
      end
      m_cur_cap = m_active && ((m_pos % (m_skip + 1)) == 0);
      if (m_active) m_pos++;
      m_cur_lines = lines;
      es = m_cur_cap;
   endtask

   task automatic drive_frame(input int lines, input int req_line, input int abort_line, input bit abort_b);
      int s0, d0, e0;
      s0 = n_start; d0 = n_done; e0 = n_err;
      bus.vsync = 1'b0;
      bus.abort = abort_b;
      @(negedge clk);
      f_start = bus.frame_start; f_done = bus.frame_done; f_err = bus.frame_err;
      tick();
      bus.abort = 1'b0;
      @(negedge clk);
      f_en_next = bus.capture_enable;
      tick();
      for (int i = 0; i < lines; i++) begin
         bus.href = 1'b1;
         if (i == req_line) begin
            bus.mode      = cfg_mode[1:0];
            bus.burst_len = cfg_len[7:0];
            bus.skip      = cfg_skip[3:0];
         end
         bus.cap_req = (i == req_line);
         bus.abort   = (i == abort_line);
         tick();
         if (i == req_line) begin
            bus.mode      = 2'($urandom);
            bus.burst_len = 8'($urandom);
            bus.skip      = 4'($urandom);
         end
         bus.href = 1'b0; bus.cap_req = 1'b0; bus.abort = 1'b0;
         tick();
      end
      tick();
      bus.vsync = 1'b1;
      tick(); tick();
      @(negedge clk);
      f_en_late = bus.capture_enable; f_busy_late = bus.busy; f_frames_late = bus.frames_captured;
      tick();
      d_start = n_start - s0; d_done = n_done - d0; d_err = n_err - e0;
   endtask

   task automatic do_frame(input int lines, input int req_line, input int abort_line, input bit abort_b);
      bit es, ed, ee, en0;
      fno++;
      if (abort_b) model_abort();
      model_boundary(lines, es, ed, ee);
      en0 = m_cur_cap;
      if (req_line >= 0 && req_line == abort_line) begin
         if (m_active) model_abort(); else model_req();
      end else begin
         if (abort_line >= 0 && (req_line < 0 || abort_line < req_line)) model_abort();
         if (req_line >= 0) model_req();
         if (abort_line >= 0 && req_line >= 0 && abort_line > req_line) model_abort();
      end
      drive_frame(lines, req_line, abort_line, abort_b);
      chk($sformatf("f%0d.start", fno), f_start, es);
      chk($sformatf("f%0d.done", fno), f_done, ed);
      chk($sformatf("f%0d.err", fno), f_err, ee);
      chk($sformatf("f%0d.n_start", fno), d_start, es);
      chk($sformatf("f%0d.n_done", fno), d_done, ed);
      chk($sformatf("f%0d.n_err", fno), d_err, ee);
      chk($sformatf("f%0d.en_next", fno), f_en_next, en0);
      chk($sformatf("f%0d.en_late", fno), f_en_late, m_cur_cap);
      chk($sformatf("f%0d.busy", fno), f_busy_late, m_active);
      chk($sformatf("f%0d.frames", fno), f_frames_late, m_frames);
   endtask

   initial begin
      int ln, mid;
      bit ab;
      reset = 1'b1;
      bus.cap_req = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0;
      bus.burst_len = 8'd0; bus.skip = 4'd0; bus.vsync = 1'b1; bus.href = 1'b0;
      repeat (3) tick();
      chk("rst.en", bus.capture_enable, 0);
      chk("rst.busy", bus.busy, 0);
      chk("rst.frames", bus.frames_captured, 0);
      chk("rst.start", bus.frame_start, 0);
      chk("rst.done", bus.frame_done, 0);
      chk("rst.err", bus.frame_err, 0);
      reset = 1'b0;
      tick(); tick();

      // Single frame, request mid-frame
      cfg_mode = 0; cfg_len = 5; cfg_skip = 3;
      do_frame(240, 100, -1, 0);
      do_frame(240, -1, -1, 0);
      do_frame(240, -1, -1, 0);

      // Burst of three back-to-back frames
      cfg_mode = 1; cfg_len = 3; cfg_skip = 0;
      do_frame(240, 50, -1, 0);
      repeat (4) do_frame(240, -1, -1, 0);

      // Burst of two with two skipped frames between
      cfg_mode = 1; cfg_len = 2; cfg_skip = 2;
      do_frame(240, 50, -1, 0);
      repeat (6) do_frame(240, -1, -1, 0);

      // Continuous, abort on the boundary that ends the fifth frame
      cfg_mode = 2; cfg_len = 0; cfg_skip = 0;
      do_frame(240, 50, -1, 0);
      repeat (5) do_frame(240, -1, -1, 0);
      do_frame(240, -1, -1, 1);

      // Short frame flags an error; then a request while busy is dropped
      cfg_mode = 0; cfg_len = 1; cfg_skip = 0;
      do_frame(240, 50, -1, 0);
      do_frame(239, -1, -1, 0);
      do_frame(240, -1, -1, 0);
      cfg_mode = 1; cfg_len = 3; cfg_skip = 0;
      do_frame(240, 50, -1, 0);
      do_frame(240, -1, -1, 0);
      cfg_mode = 0; cfg_len = 1;
      do_frame(240, 30, -1, 0);
      do_frame(240, 30, -1, 0);
      do_frame(240, -1, -1, 0);

      // Asynchronous reset in the middle of a captured frame
      cfg_mode = 1; cfg_len = 3; cfg_skip = 0;
      do_frame(240, 50, -1, 0);
      do_frame(240, -1, -1, 0);
      do_frame(240, -1, -1, 0);
      bus.vsync = 1'b0;
      tick(); tick();
      for (int i = 0; i < 20; i++) begin
         bus.href = 1'b1; tick(); bus.href = 1'b0; tick();
      end
      @(negedge clk);
      chk("pre_rst.en", bus.capture_enable, 1);
      chk("pre_rst.busy", bus.busy, 1);
      chk("pre_rst.frames", bus.frames_captured, 2);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst.en", bus.capture_enable, 0);
      chk("async_rst.busy", bus.busy, 0);
      chk("async_rst.frames", bus.frames_captured, 0);
      chk("async_rst.start", bus.frame_start, 0);
      chk("async_rst.done", bus.frame_done, 0);
      chk("async_rst.err", bus.frame_err, 0);
      bus.vsync = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      m_active = 0; m_cur_cap = 0; m_frames = 0;
      do_frame(240, -1, -1, 0);

      // Randomised sessions
      for (int s = 0; s < 5; s++) begin
         cfg_mode = $urandom_range(0, 3);
         cfg_len  = $urandom_range(0, 4);
         cfg_skip = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) do_frame(240, 20, 20, 0);
         else                           do_frame(240, 20, -1, 0);
         for (int k = 0; k < 8 && m_active; k++) begin
            ln  = ($urandom_range(0, 2) == 0) ? $urandom_range(236, 244) : 240;
            ab  = ($urandom_range(0, 11) == 0);
            mid = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 200) : -1;
            do_frame(ln, -1, mid, ab);
         end
         if (m_active) do_frame(240, -1, -1, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
